// File: rtl/rvh_l1d_amo_exec_if.sv
// Handshake and payload bundle for the AMO executor: request in, bank read/write out,
// and ROB writeback out. Each modport is named from one side's point of view.
interface rvh_l1d_amo_exec_if #(
   parameter int XLEN           = 64,
   parameter int PADDR_WIDTH    = 56,
   parameter int ROB_TAG_WIDTH  = 4,
   parameter int PREG_TAG_WIDTH = 6,
   parameter int STU_OP_WIDTH   = 5
);
   // request from the AMO controller
   logic                      amo_req_vld;
   logic                      amo_req_rdy;
   logic [ROB_TAG_WIDTH-1:0]  amo_req_rob_tag;
   logic [PREG_TAG_WIDTH-1:0] amo_req_prd;
   logic [STU_OP_WIDTH-1:0]   amo_req_opcode;
   logic [PADDR_WIDTH-1:0]    amo_req_paddr;
   logic [XLEN-1:0]           amo_req_data;
   logic                      amo_req_sc_succ;
   // bank read
   logic                      bank_rd_vld;
   logic                      bank_rd_rdy;
   logic [PADDR_WIDTH-1:0]    bank_rd_paddr;
   logic                      bank_rd_resp_vld;
   logic [XLEN-1:0]           bank_rd_resp_data;
   // bank write
   logic                      bank_wr_vld;
   logic                      bank_wr_rdy;
   logic [PADDR_WIDTH-1:0]    bank_wr_paddr;
   logic [XLEN-1:0]           bank_wr_data;
   logic [7:0]                bank_wr_mask;
   // ROB writeback
   logic                      wb_vld;
   logic                      wb_rdy;
   logic [ROB_TAG_WIDTH-1:0]  wb_rob_tag;
   logic [PREG_TAG_WIDTH-1:0] wb_prd;
   logic [XLEN-1:0]           wb_data;

   // executor side
   modport slave (
      input  amo_req_vld, amo_req_rob_tag, amo_req_prd, amo_req_opcode,
             amo_req_paddr, amo_req_data, amo_req_sc_succ,
             bank_rd_rdy, bank_rd_resp_vld, bank_rd_resp_data, bank_wr_rdy, wb_rdy,
      output amo_req_rdy, bank_rd_vld, bank_rd_paddr, bank_wr_vld, bank_wr_paddr,
             bank_wr_data, bank_wr_mask, wb_vld, wb_rob_tag, wb_prd, wb_data
   );

   // environment side (controller, bank, ROB)
   modport master (
      output amo_req_vld, amo_req_rob_tag, amo_req_prd, amo_req_opcode,
             amo_req_paddr, amo_req_data, amo_req_sc_succ,
             bank_rd_rdy, bank_rd_resp_vld, bank_rd_resp_data, bank_wr_rdy, wb_rdy,
      input  amo_req_rdy, bank_rd_vld, bank_rd_paddr, bank_wr_vld, bank_wr_paddr,
             bank_wr_data, bank_wr_mask, wb_vld, wb_rob_tag, wb_prd, wb_data
   );
endinterface

// File: rtl/rvh_l1d_amo_exec.sv
// Single-entry AMO executor: read-modify-write of one dword in an L1D bank,
// then writeback of the old value (or the SC status) to the ROB.
module rvh_l1d_amo_exec #(
   parameter int XLEN           = 64,
   parameter int PADDR_WIDTH    = 56,
   parameter int ROB_TAG_WIDTH  = 4,
   parameter int PREG_TAG_WIDTH = 6,
   parameter int STU_OP_WIDTH   = 5
)(
   input logic               clk,
   input logic               rst,
   rvh_l1d_amo_exec_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_WAIT, S_WR, S_WB} state_t;

   // operation kind = (opcode - 7) >> 1; opcode bit 0 set means the .W flavour
   localparam logic [3:0] K_LR   = 4'd0;
   localparam logic [3:0] K_SC   = 4'd1;
   localparam logic [3:0] K_SWAP = 4'd2;
   localparam logic [3:0] K_ADD  = 4'd3;
   localparam logic [3:0] K_AND  = 4'd4;
   localparam logic [3:0] K_OR   = 4'd5;
   localparam logic [3:0] K_XOR  = 4'd6;
   localparam logic [3:0] K_MAX  = 4'd7;
   localparam logic [3:0] K_MAXU = 4'd8;
   localparam logic [3:0] K_MIN  = 4'd9;
   localparam logic [3:0] K_MINU = 4'd10;

   function automatic logic [3:0] op_kind(input logic [STU_OP_WIDTH-1:0] op);
      logic [STU_OP_WIDTH-1:0] t;
      t = op - STU_OP_WIDTH'(7);
      return 4'(t >> 1);
   endfunction

   state_t                    state, state_nxt;
   logic [STU_OP_WIDTH-1:0]   op_q;
   logic                      word_hi_q;
   logic [XLEN-1:0]           rs2_q;
   logic [PADDR_WIDTH-1:0]    addr_q;
   logic [ROB_TAG_WIDTH-1:0]  tag_q;
   logic [PREG_TAG_WIDTH-1:0] prd_q;
   logic [XLEN-1:0]           wr_data_q;
   logic [7:0]                wr_mask_q;
   logic [XLEN-1:0]           wb_data_q;

   logic [3:0]  req_kind, kind_q;
   logic        req_w, is_w_q;
   logic [31:0] old32, b32, res32;
   logic [XLEN-1:0] old64, res64;
   logic        accept, resp_take;
   logic        unused_paddr_bits;

   assign req_kind  = op_kind(bus.amo_req_opcode);
   assign req_w     = bus.amo_req_opcode[0];
   assign kind_q    = op_kind(op_q);
   assign is_w_q    = op_q[0];
   assign accept    = (state == S_IDLE) && bus.amo_req_vld;
   assign resp_take = (state == S_RD_WAIT) && bus.bank_rd_resp_vld;
   // sub-word offset below the word boundary has no effect on an AMO
   assign unused_paddr_bits = ^bus.amo_req_paddr[1:0];

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.amo_req_vld) begin
               if (req_kind == K_SC) state_nxt = bus.amo_req_sc_succ ? S_WR : S_WB;
               else                  state_nxt = S_RD;
            end
         end
         S_RD:      if (bus.bank_rd_rdy)      state_nxt = S_RD_WAIT;
         S_RD_WAIT: if (bus.bank_rd_resp_vld) state_nxt = (kind_q == K_LR) ? S_WB : S_WR;
         S_WR:      if (bus.bank_wr_rdy)      state_nxt = S_WB;
         S_WB:      if (bus.wb_rdy)           state_nxt = S_IDLE;
         default:                             state_nxt = S_IDLE;
      endcase
   end

   // handshake outputs are pure decodes of the state register
   always_comb begin
      bus.amo_req_rdy = (state == S_IDLE);
      bus.bank_rd_vld = (state == S_RD);
      bus.bank_wr_vld = (state == S_WR);
      bus.wb_vld      = (state == S_WB);
   end

   assign bus.bank_rd_paddr = addr_q;
   assign bus.bank_wr_paddr = addr_q;
   assign bus.bank_wr_data  = wr_data_q;
   assign bus.bank_wr_mask  = wr_mask_q;
   assign bus.wb_rob_tag    = tag_q;
   assign bus.wb_prd        = prd_q;
   assign bus.wb_data       = wb_data_q;

   // ALU on the returned dword; both widths computed, the latch picks one
   always_comb begin
      old64 = bus.bank_rd_resp_data;
      old32 = word_hi_q ? bus.bank_rd_resp_data[63:32] : bus.bank_rd_resp_data[31:0];
      b32   = rs2_q[31:0];
      res32 = old32;
      res64 = old64;
      case (kind_q)
         K_SWAP: begin res32 = b32;          res64 = rs2_q;          end
         K_ADD:  begin res32 = old32 + b32;  res64 = old64 + rs2_q;  end
         K_AND:  begin res32 = old32 & b32;  res64 = old64 & rs2_q;  end
         K_OR:   begin res32 = old32 | b32;  res64 = old64 | rs2_q;  end
         K_XOR:  begin res32 = old32 ^ b32;  res64 = old64 ^ rs2_q;  end
         K_MAX: begin
            res32 = ($signed(old32) > $signed(b32))   ? old32 : b32;
            res64 = ($signed(old64) > $signed(rs2_q)) ? old64 : rs2_q;
         end
         K_MAXU: begin
            res32 = (old32 > b32)   ? old32 : b32;
            res64 = (old64 > rs2_q) ? old64 : rs2_q;
         end
         K_MIN: begin
            res32 = ($signed(old32) < $signed(b32))   ? old32 : b32;
            res64 = ($signed(old64) < $signed(rs2_q)) ? old64 : rs2_q;
         end
         K_MINU: begin
            res32 = (old32 < b32)   ? old32 : b32;
            res64 = (old64 < rs2_q) ? old64 : rs2_q;
         end
         default: ;
      endcase
   end

   // request latch on accept; write data and writeback value filled on the read response.
   // SC decides both values at accept time since it never reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q      <= '0;
         word_hi_q <= 1'b0;
         rs2_q     <= '0;
         addr_q    <= '0;
         tag_q     <= '0;
         prd_q     <= '0;
         wr_data_q <= '0;
         wr_mask_q <= '0;
         wb_data_q <= '0;
      end else if (accept) begin
         op_q      <= bus.amo_req_opcode;
         word_hi_q <= bus.amo_req_paddr[2];
         rs2_q     <= bus.amo_req_data;
         addr_q    <= {bus.amo_req_paddr[PADDR_WIDTH-1:3], 3'b000};
         tag_q     <= bus.amo_req_rob_tag;
         prd_q     <= bus.amo_req_prd;
         wr_mask_q <= !req_w ? 8'hFF : (bus.amo_req_paddr[2] ? 8'hF0 : 8'h0F);
         wr_data_q <= req_w ? {2{bus.amo_req_data[31:0]}} : bus.amo_req_data;
         wb_data_q <= bus.amo_req_sc_succ ? '0 : XLEN'(1);
      end else if (resp_take) begin
         wr_data_q <= is_w_q ? {2{res32}} : res64;
         wb_data_q <= is_w_q ? {{(XLEN-32){old32[31]}}, old32} : old64;
      end
   end
endmodule

// File: tb/tb_rvh_l1d_amo_exec.sv
// Directed bench for rvh_l1d_amo_exec: the bench acts as controller, bank and ROB,
// pushes expected bank/writeback transactions to queues and pops them on handshakes.
module tb_rvh_l1d_amo_exec;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rvh_l1d_amo_exec_if bus ();
   rvh_l1d_amo_exec dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct { logic [55:0] a; logic [63:0] d; logic [7:0] m; } wr_t;
   typedef struct { logic [3:0] tag; logic [5:0] prd; logic [63:0] d; } wb_t;

   logic [55:0] q_rd[$];
   wr_t         q_wr[$];
   wb_t         q_wb[$];

   int n_cmp = 0;
   int n_bad = 0;
   int tag_ctr = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // reference behaviour of one AMO
   function automatic void model(input logic [4:0] op, input logic [55:0] pa,
                                 input logic [63:0] rs2, input logic sc_ok, input logic [63:0] mem,
                                 output logic do_rd, output logic do_wr, output logic [63:0] wdata,
                                 output logic [7:0] mask, output logic [63:0] wbd);
      int k;
      logic w;
      logic [31:0] o, b, r;
      logic [63:0] r64;
      k = (int'(op) - 7) / 2;
      w = op[0];
      o = pa[2] ? mem[63:32] : mem[31:0];
      b = rs2[31:0];
      r = b;
      r64 = rs2;
      case (k)
         3: begin r = o + b; r64 = mem + rs2; end
         4: begin r = o & b; r64 = mem & rs2; end
         5: begin r = o | b; r64 = mem | rs2; end
         6: begin r = o ^ b; r64 = mem ^ rs2; end
         7: begin
            r   = ($signed(o) >= $signed(b)) ? o : b;
            r64 = ($signed(mem) >= $signed(rs2)) ? mem : rs2;
         end
         8: begin r = (o >= b) ? o : b; r64 = (mem >= rs2) ? mem : rs2; end
         9: begin
            r   = ($signed(o) <= $signed(b)) ? o : b;
            r64 = ($signed(mem) <= $signed(rs2)) ? mem : rs2;
         end
         10: begin r = (o <= b) ? o : b; r64 = (mem <= rs2) ? mem : rs2; end
         default: ;
      endcase
      mask  = !w ? 8'hFF : (pa[2] ? 8'hF0 : 8'h0F);
      do_rd = (k != 1);
      do_wr = (k != 0) && !(k == 1 && !sc_ok);
      wdata = w ? {r, r} : r64;
      if (k == 1) wbd = sc_ok ? 64'd0 : 64'd1;
      else        wbd = w ? {{32{o[31]}}, o} : mem;
   endfunction

   // runs one operation from a negedge where the DUT is idle; e_* are expected
   // handshake cycles relative to the accept cycle (-1 = not checked)
   task automatic do_op(input string nm, input logic [4:0] op, input logic [55:0] pa,
                        input logic [63:0] rs2, input logic sc_ok, input logic [63:0] mem,
                        input int rd_st, input int wr_st, input int wb_st,
                        input int e_rd, input int e_wr, input int e_wb, input int e_idle);
      logic do_rd, do_wr;
      logic [63:0] wd, wbd;
      logic [7:0] mk;
      logic [55:0] ea;
      wr_t ew;
      wb_t eb;
      int cyc, n_rd, n_wr, n_wb, rs, ws, bs, exp_rd, exp_wr;
      bit pend, done;
      model(op, pa, rs2, sc_ok, mem, do_rd, do_wr, wd, mk, wbd);
      tag_ctr++;
      if (do_rd) q_rd.push_back({pa[55:3], 3'b000});
      if (do_wr) q_wr.push_back(wr_t'{a: {pa[55:3], 3'b000}, d: wd, m: mk});
      q_wb.push_back(wb_t'{tag: 4'(tag_ctr), prd: 6'(tag_ctr * 5), d: wbd});
      exp_rd = q_rd.size();
      exp_wr = q_wr.size();
      check({nm, ":req_rdy"}, 64'(bus.amo_req_rdy), 64'd1);
      bus.amo_req_vld     = 1'b1;
      bus.amo_req_opcode  = op;
      bus.amo_req_paddr   = pa;
      bus.amo_req_data    = rs2;
      bus.amo_req_sc_succ = sc_ok;
      bus.amo_req_rob_tag = 4'(tag_ctr);
      bus.amo_req_prd     = 6'(tag_ctr * 5);
      rs = rd_st; ws = wr_st; bs = wb_st;
      n_rd = 0; n_wr = 0; n_wb = 0; pend = 0; done = 0;
      @(negedge clk);
      cyc = 1;
      bus.amo_req_vld = 1'b0;
      while (1) begin
         bus.bank_rd_resp_vld = 1'b0;
         if (pend) begin
            bus.bank_rd_resp_vld  = 1'b1;
            bus.bank_rd_resp_data = mem;
            pend = 0;
         end
         bus.bank_rd_rdy = 1'b0;
         bus.bank_wr_rdy = 1'b0;
         bus.wb_rdy      = 1'b0;
         if (bus.bank_rd_vld) begin
            if (q_rd.size() == 0) begin
               check({nm, ":unexpected_rd"}, 64'(bus.bank_rd_vld), 64'd0);
               bus.bank_rd_rdy = 1'b1; pend = 1;
            end else if (rs > 0) begin
               check({nm, ":rd_stable"}, 64'(bus.bank_rd_paddr), 64'(q_rd[0]));
               rs--;
            end else begin
               ea = q_rd.pop_front();
               bus.bank_rd_rdy = 1'b1; pend = 1; n_rd++;
               check({nm, ":rd_paddr"}, 64'(bus.bank_rd_paddr), 64'(ea));
               if (e_rd >= 0) check({nm, ":rd_cyc"}, 64'(cyc), 64'(e_rd));
            end
         end
         if (bus.bank_wr_vld) begin
            if (q_wr.size() == 0) begin
               check({nm, ":unexpected_wr"}, 64'(bus.bank_wr_vld), 64'd0);
               bus.bank_wr_rdy = 1'b1;
            end else if (ws > 0) begin
               check({nm, ":wr_data_stable"}, bus.bank_wr_data, q_wr[0].d);
               check({nm, ":wr_mask_stable"}, 64'(bus.bank_wr_mask), 64'(q_wr[0].m));
               ws--;
            end else begin
               ew = q_wr.pop_front();
               bus.bank_wr_rdy = 1'b1; n_wr++;
               check({nm, ":wr_paddr"}, 64'(bus.bank_wr_paddr), 64'(ew.a));
               check({nm, ":wr_data"}, bus.bank_wr_data, ew.d);
               check({nm, ":wr_mask"}, 64'(bus.bank_wr_mask), 64'(ew.m));
               if (e_wr >= 0) check({nm, ":wr_cyc"}, 64'(cyc), 64'(e_wr));
            end
         end
         if (bus.wb_vld && q_wb.size() != 0) begin
            if (bs > 0) begin
               check({nm, ":wb_data_stable"}, bus.wb_data, q_wb[0].d);
               bs--;
            end else begin
               eb = q_wb.pop_front();
               bus.wb_rdy = 1'b1; n_wb++; done = 1;
               check({nm, ":wb_tag"}, 64'(bus.wb_rob_tag), 64'(eb.tag));
               check({nm, ":wb_prd"}, 64'(bus.wb_prd), 64'(eb.prd));
               check({nm, ":wb_data"}, bus.wb_data, eb.d);
               check({nm, ":rdy_in_wb"}, 64'(bus.amo_req_rdy), 64'd0);
               if (e_wb >= 0) check({nm, ":wb_cyc"}, 64'(cyc), 64'(e_wb));
            end
         end
         if (done || cyc >= 60) break;
         @(negedge clk);
         cyc++;
      end
      check({nm, ":completed"}, 64'(done), 64'd1);
      @(negedge clk);
      cyc++;
      bus.bank_rd_rdy = 1'b0;
      bus.bank_wr_rdy = 1'b0;
      bus.wb_rdy      = 1'b0;
      bus.bank_rd_resp_vld = 1'b0;
      check({nm, ":idle_rdy"}, 64'(bus.amo_req_rdy), 64'd1);
      if (e_idle >= 0) check({nm, ":idle_cyc"}, 64'(cyc), 64'(e_idle));
      check({nm, ":n_rd"}, 64'(n_rd), 64'(exp_rd));
      check({nm, ":n_wr"}, 64'(n_wr), 64'(exp_wr));
      check({nm, ":rd_q_left"}, 64'(q_rd.size()), 64'd0);
      check({nm, ":wr_q_left"}, 64'(q_wr.size()), 64'd0);
   endtask

   initial begin
      bus.amo_req_vld = 1'b0; bus.amo_req_rob_tag = '0; bus.amo_req_prd = '0;
      bus.amo_req_opcode = '0; bus.amo_req_paddr = '0; bus.amo_req_data = '0;
      bus.amo_req_sc_succ = 1'b0; bus.bank_rd_rdy = 1'b0; bus.bank_rd_resp_vld = 1'b0;
      bus.bank_rd_resp_data = '0; bus.bank_wr_rdy = 1'b0; bus.wb_rdy = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst:req_rdy", 64'(bus.amo_req_rdy), 64'd1);
      check("rst:rd_vld", 64'(bus.bank_rd_vld), 64'd0);
      check("rst:wr_vld", 64'(bus.bank_wr_vld), 64'd0);
      check("rst:wb_vld", 64'(bus.wb_vld), 64'd0);
      check("rst:rd_paddr", 64'(bus.bank_rd_paddr), 64'd0);
      check("rst:wr_data", bus.bank_wr_data, 64'd0);
      check("rst:wr_mask", 64'(bus.bank_wr_mask), 64'd0);
      check("rst:wb_data", bus.wb_data, 64'd0);
      check("rst:wb_tag", 64'(bus.wb_rob_tag), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      do_op("amoadd_d", 5'd14, 56'h1008, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 3, 4, 5);
      do_op("amomax_w", 5'd21, 56'h2004, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 0, 0, 0, 1, 3, 4, 5);
      do_op("amomaxu_w", 5'd23, 56'h2004, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 0, 0, 0, 1, 3, 4, 5);
      do_op("lr_w", 5'd7, 56'h3000, 64'd0, 1'b0, 64'h1234_5678_8765_4321, 0, 0, 0, 1, -1, 3, 4);
      do_op("sc_d_ok", 5'd10, 56'h4000, 64'hAA, 1'b1, 64'd0, 0, 0, 0, -1, 1, 2, 3);
      do_op("sc_d_fail", 5'd10, 56'h4000, 64'hAA, 1'b0, 64'd0, 0, 0, 0, -1, -1, 1, 2);
      do_op("sc_w_hi", 5'd9, 56'h4004, 64'h1111_2222_3333_4444, 1'b1, 64'd0, 0, 0, 0, -1, 1, 2, 3);
      do_op("bp_xor_w", 5'd19, 56'h0043, 64'hFF00_FF00_0F0F_0F0F, 1'b0, 64'hDEAD_BEEF_CAFE_F00D,
            3, 3, 3, 4, 9, 13, 14);

      // reset while waiting for the read response
      bus.amo_req_vld = 1'b1; bus.amo_req_opcode = 5'd14; bus.amo_req_paddr = 56'h5000;
      bus.amo_req_data = 64'd7; bus.amo_req_rob_tag = 4'd9; bus.amo_req_prd = 6'd9;
      @(negedge clk);
      bus.amo_req_vld = 1'b0;
      bus.bank_rd_rdy = 1'b1;
      @(negedge clk);
      bus.bank_rd_rdy = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("midrst:req_rdy", 64'(bus.amo_req_rdy), 64'd1);
      check("midrst:rd_vld", 64'(bus.bank_rd_vld), 64'd0);
      check("midrst:wr_vld", 64'(bus.bank_wr_vld), 64'd0);
      check("midrst:wb_vld", 64'(bus.wb_vld), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      bus.bank_rd_resp_vld = 1'b1;
      bus.bank_rd_resp_data = 64'h1234;
      bus.bank_wr_rdy = 1'b1;
      bus.wb_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.bank_rd_resp_vld = 1'b0;
         check("stray:wr_vld", 64'(bus.bank_wr_vld), 64'd0);
         check("stray:wb_vld", 64'(bus.wb_vld), 64'd0);
         check("stray:req_rdy", 64'(bus.amo_req_rdy), 64'd1);
      end
      bus.bank_wr_rdy = 1'b0;
      bus.wb_rdy = 1'b0;
      do_op("post_rst_add", 5'd14, 56'h5000, 64'd7, 1'b0, 64'd100, 0, 0, 0, 1, 3, 4, 5);

      // sweep every opcode with random operands and addresses
      for (int op = 7; op <= 28; op++) begin
         do_op("sweep", 5'(op), 56'({$urandom(), $urandom()}), {$urandom(), $urandom()},
               1'($urandom_range(0, 1)), {$urandom(), $urandom()}, 0, 0, 0, -1, -1, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
